// File: rtl/uart_frame_rx_pkg.sv
// uart_frame_rx_pkg: parser state encoding and frame defaults shared by the frame receiver
package uart_frame_rx_pkg;
  typedef enum logic [2:0] {FR_HUNT, FR_CMD, FR_LEN, FR_PAYLOAD, FR_CHK} fr_state_t;
  localparam int MAX_LEN_DEF = 16;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int TIMEOUT_DEF = 1024;
endpackage

// File: rtl/uart_frame_rx_if.sv
// uart_frame_rx_if: held-frame handshake and payload read port between receiver and consumer
interface uart_frame_rx_if import uart_frame_rx_pkg::*; #(parameter int MAX_LEN = MAX_LEN_DEF);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  logic frame_valid;
  logic [7:0] frame_cmd;
  logic [LW-1:0] frame_len;
  logic frame_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0] rd_data;
  modport master(output frame_valid, frame_cmd, frame_len, rd_data, input frame_ack, rd_addr);
  modport slave(input frame_valid, frame_cmd, frame_len, rd_data, output frame_ack, rd_addr);
endinterface

// File: rtl/uart_frame_rx_frame_buf.sv
// uart_frame_rx_frame_buf: payload memory, one write port and one registered read port
module uart_frame_rx_frame_buf import uart_frame_rx_pkg::*; #(
  parameter int DEPTH = MAX_LEN_DEF,
  parameter int AW = $clog2(MAX_LEN_DEF)
) (
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0] rdata
);
  logic [7:0] mem [DEPTH];
  // write port, no reset so the array maps onto block/distributed RAM
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // registered read with resettable output register
  always_ff @(posedge clk)
    rdata <= reset ? 8'd0 : mem[raddr];
endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: hunts for SYNC, assembles and validates CMD/LEN/PAYLOAD/CHK frames, holds them until ack
module uart_frame_rx import uart_frame_rx_pkg::*; #(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic [7:0] data_received,
  input  logic rx_done,
  input  logic parity_error,
  uart_frame_rx_if.master bus,
  output logic err_parity,
  output logic err_len,
  output logic err_chk,
  output logic err_timeout,
  output logic err_overrun
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);
  fr_state_t state;
  logic rx_done_q, drop, valid;
  logic [7:0] chk, cmd_q, cmd_out;
  logic [LW-1:0] len_q, len_out;
  logic [AW-1:0] idx;
  logic [TW-1:0] tcnt;
  logic byte_stb, tmo, we;
  assign byte_stb = rx_done & ~rx_done_q;
  // a byte arriving on the compare cycle wins, so a gap of TIMEOUT-1 idle cycles survives
  assign tmo = state != FR_HUNT && !byte_stb && tcnt == TW'(TIMEOUT - 1);
  assign we = byte_stb && state == FR_PAYLOAD && !parity_error && !drop;
  assign bus.frame_valid = valid;
  assign bus.frame_cmd = cmd_out;
  assign bus.frame_len = len_out;
  uart_frame_rx_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk(clk), .reset(reset), .we(we), .waddr(idx), .wdata(data_received),
    .raddr(bus.rd_addr), .rdata(bus.rd_data)
  );
  // frame parser: byte strobe edge detect, FSM, checksum, timeout, held-frame latch and error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FR_HUNT;
      rx_done_q <= 1'b1;
      valid <= 1'b0;
      drop <= 1'b0;
      chk <= '0;
      cmd_q <= '0;
      len_q <= '0;
      idx <= '0;
      tcnt <= '0;
      cmd_out <= '0;
      len_out <= '0;
      err_parity <= 1'b0;
      err_len <= 1'b0;
      err_chk <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      err_parity <= byte_stb && parity_error;
      err_len <= 1'b0;
      err_chk <= 1'b0;
      err_timeout <= tmo;
      err_overrun <= 1'b0;
      tcnt <= (byte_stb || state == FR_HUNT) ? '0 : tcnt + 1'b1;
      if (bus.frame_ack) valid <= 1'b0;
      if (tmo || (byte_stb && parity_error)) state <= FR_HUNT;
      else if (byte_stb) begin
        unique case (state)
          FR_HUNT: if (data_received == SYNC_BYTE) begin
            state <= FR_CMD;
            chk <= '0;
            drop <= valid;
          end
          FR_CMD: begin
            cmd_q <= data_received;
            chk <= chk ^ data_received;
            state <= FR_LEN;
          end
          FR_LEN: begin
            len_q <= LW'(data_received);
            chk <= chk ^ data_received;
            idx <= '0;
            err_len <= data_received > MAX_B;
            state <= data_received > MAX_B ? FR_HUNT : data_received == 8'd0 ? FR_CHK : FR_PAYLOAD;
          end
          FR_PAYLOAD: begin
            chk <= chk ^ data_received;
            idx <= idx + 1'b1;
            if (LW'(idx) + 1'b1 == len_q) state <= FR_CHK;
          end
          FR_CHK: begin
            state <= FR_HUNT;
            if (data_received != chk) err_chk <= 1'b1;
            else if (drop) err_overrun <= 1'b1;
            else begin
              valid <= 1'b1;
              cmd_out <= cmd_q;
              len_out <= len_q;
            end
          end
          default: state <= FR_HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed plus randomized frames checked against a frame-level reference model
module tb_uart_frame_rx;
  typedef logic [7:0] q8_t[$];
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] data_received = 8'hA5;
  logic rx_done = 1'b1, parity_error = 1'b0;
  logic err_parity, err_len, err_chk, err_timeout, err_overrun;
  int total = 0, bad = 0;
  int n_par = 0, n_len = 0, n_chk = 0, n_tmo = 0, n_ovr = 0;
  int e_par = 0, e_len = 0, e_chk = 0, e_tmo = 0, e_ovr = 0;
  logic m_valid = 1'b0;
  logic [7:0] m_cmd = 8'h00;
  int m_len = 0;
  logic [7:0] m_pl [16];

  uart_frame_rx_if bus();
  uart_frame_rx dut (
    .clk(clk), .reset(reset), .data_received(data_received), .rx_done(rx_done),
    .parity_error(parity_error), .bus(bus), .err_parity(err_parity), .err_len(err_len),
    .err_chk(err_chk), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset) begin
      n_par += int'(err_parity);
      n_len += int'(err_len);
      n_chk += int'(err_chk);
      n_tmo += int'(err_timeout);
      n_ovr += int'(err_overrun);
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic q8_t mk(input logic [7:0] cmd, input q8_t pl);
    q8_t q;
    logic [7:0] x;
    x = cmd ^ 8'(pl.size());
    q = {8'hA5, cmd, 8'(pl.size())};
    foreach (pl[i]) begin
      q.push_back(pl[i]);
      x ^= pl[i];
    end
    q.push_back(x);
    return q;
  endfunction

  task automatic hold(input logic [7:0] cmd, input q8_t pl);
    m_valid = 1'b1;
    m_cmd = cmd;
    m_len = pl.size();
    foreach (pl[i]) m_pl[i] = pl[i];
  endtask

  task automatic send_byte(input logic [7:0] b, input logic p);
    data_received = b;
    parity_error = p;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    parity_error = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_seq(input q8_t q);
    foreach (q[i]) send_byte(q[i], 1'b0);
  endtask

  task automatic do_ack();
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
    m_valid = 1'b0;
    check("ack valid", 32'(bus.frame_valid), 32'd0);
  endtask

  task automatic verify(input string tag);
    repeat (3) @(negedge clk);
    check({tag, " err_parity"}, n_par, e_par);
    check({tag, " err_len"}, n_len, e_len);
    check({tag, " err_chk"}, n_chk, e_chk);
    check({tag, " err_timeout"}, n_tmo, e_tmo);
    check({tag, " err_overrun"}, n_ovr, e_ovr);
    check({tag, " valid"}, 32'(bus.frame_valid), 32'(m_valid));
    if (m_valid) begin
      check({tag, " cmd"}, 32'(bus.frame_cmd), 32'(m_cmd));
      check({tag, " len"}, 32'(bus.frame_len), 32'(m_len));
      for (int i = 0; i < m_len; i++) begin
        bus.rd_addr = 4'(i);
        @(negedge clk);
        check($sformatf("%s rd[%0d]", tag, i), 32'(bus.rd_data), 32'(m_pl[i]));
      end
    end
  endtask

  task automatic run_frame(input int len, input bit good, input bit par);
    q8_t q, pl;
    logic [7:0] cmd;
    int ppos;
    cmd = 8'($urandom);
    for (int i = 0; i < len && i < 16; i++) pl.push_back(8'($urandom));
    q = mk(cmd, pl);
    if (len > 16) begin
      q = {8'hA5, cmd, 8'(len)};
    end else if (!good) q[q.size() - 1] = q[q.size() - 1] ^ 8'($urandom_range(1, 255));
    ppos = par ? $urandom_range(1, q.size() - 1) : q.size();
    for (int i = 0; i < q.size() && i <= ppos; i++) send_byte(q[i], i == ppos);
    if (par) e_par++;
    else if (len > 16) e_len++;
    else if (!good) e_chk++;
    else if (m_valid) e_ovr++;
    else hold(cmd, pl);
  endtask

  initial begin
    q8_t f, pl;
    bus.frame_ack = 1'b0;
    bus.rd_addr = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    check("rst valid", 32'(bus.frame_valid), 32'd0);
    check("rst cmd", 32'(bus.frame_cmd), 32'd0);
    check("rst len", 32'(bus.frame_len), 32'd0);
    check("rst rd_data", 32'(bus.rd_data), 32'd0);
    check("rst errs", 32'({err_parity, err_len, err_chk, err_timeout, err_overrun}), 32'd0);
    repeat (3) @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
    pl = {};
    send_seq(mk(8'h07, pl));
    hold(8'h07, pl);
    verify("len0");
    do_ack();
    pl = {8'h11, 8'h22, 8'h33};
    send_seq(mk(8'h12, pl));
    hold(8'h12, pl);
    verify("good");
    do_ack();
    send_seq({8'hA5, 8'h12, 8'h01, 8'h44, 8'h00});
    e_chk++;
    verify("badchk");
    send_seq({8'h00, 8'hFF, 8'hA5, 8'h12, 8'h03, 8'h11, 8'h22});
    send_byte(8'h33, 1'b1);
    e_par++;
    verify("parity");
    send_seq({8'hA5, 8'h12, 8'd17});
    e_len++;
    verify("len17");
    send_seq({8'hA5, 8'h12, 8'h03});
    repeat (1023) @(negedge clk);
    e_tmo++;
    verify("gap1024");
    pl = {8'h5A};
    f = mk(8'h12, pl);
    send_seq(f[0:2]);
    repeat (1022) @(negedge clk);
    send_seq(f[3:4]);
    hold(8'h12, pl);
    verify("gap1023");
    pl = {8'h01, 8'h02};
    send_seq(mk(8'h33, pl));
    e_ovr++;
    verify("overrun");
    f = mk(8'h34, pl);
    f[5] = ~f[5];
    send_seq(f);
    e_chk++;
    verify("drop badchk");
    pl = {8'hAA};
    f = mk(8'h44, pl);
    send_seq(f[0:2]);
    do_ack();
    send_seq(f[3:4]);
    e_ovr++;
    verify("ack midframe");
    pl = {8'h77};
    send_seq(mk(8'h21, pl));
    hold(8'h21, pl);
    verify("held");
    pl = {8'h66};
    f = mk(8'h22, pl);
    send_seq(f[0:3]);
    data_received = f[4];
    rx_done = 1'b1;
    bus.frame_ack = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    bus.frame_ack = 1'b0;
    @(negedge clk);
    m_valid = 1'b0;
    e_ovr++;
    verify("ack+chk");
    pl = {8'h10, 8'h20};
    send_seq(mk(8'h55, pl));
    hold(8'h55, pl);
    verify("pre reset");
    send_seq({8'hA5, 8'h12, 8'h02, 8'h01});
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_valid = 1'b0;
    verify("mid reset");
    for (int n = 0; n < 40; n++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        logic [7:0] b;
        logic p;
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        p = $urandom_range(0, 3) == 0;
        send_byte(b, p);
        if (p) e_par++;
      end
      run_frame($urandom_range(0, 18), $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
      verify($sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) do_ack();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
